// File: rtl/board_drop_engine_pkg.sv
// Shared definitions for the board drop engine: FSM encoding, player ids and
// the bitmap cell-index helper.
package board_drop_engine_pkg;

    typedef enum logic [1:0] {
        S_READY  = 2'd0,
        S_COMMIT = 2'd1,
        S_CHECK  = 2'd2,
        S_END    = 2'd3
    } state_e;

    localparam logic PLAYER1 = 1'b0;
    localparam logic PLAYER2 = 1'b1;

    // Bitmap position of a cell: row-major, row 0 at the bottom.
    function automatic int unsigned cell_idx(input int unsigned row,
                                             input int unsigned col,
                                             input int unsigned cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/board_drop_engine_if.sv
// Drop request handshake between a player front end and the drop engine.
interface board_drop_engine_if #(
    parameter int unsigned COLS = 4
) ();
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic          drop_valid;
    logic [CW-1:0] drop_column;
    logic          drop_ready;
    logic          drop_accept;
    logic          drop_reject;

    modport master (
        output drop_valid, drop_column,
        input  drop_ready, drop_accept, drop_reject
    );

    modport slave (
        input  drop_valid, drop_column,
        output drop_ready, drop_accept, drop_reject
    );
endinterface

// File: rtl/board_win_detect.sv
// Combinational run detector: flags any horizontal or vertical run of WIN_LEN
// filled cells sharing one owner, and reports that owner.
module board_win_detect
    import board_drop_engine_pkg::*;
#(
    parameter int unsigned ROWS    = 4,
    parameter int unsigned COLS    = 4,
    parameter int unsigned WIN_LEN = 4
) (
    input  logic [ROWS*COLS-1:0] gameboard_i,
    input  logic [ROWS*COLS-1:0] players_i,
    output logic                 win_valid_c,
    output logic                 winner_c
);
    localparam int unsigned CELLS = ROWS * COLS;
    localparam int unsigned IW    = (CELLS > 1) ? $clog2(CELLS) : 1;

    logic        run_filled;
    logic        run_p1;
    logic        run_p2;
    int unsigned rr;
    int unsigned cc;

    // Slide a WIN_LEN window from every cell, rightwards (dir 0) and upwards (dir 1).
    always_comb begin
        win_valid_c = 1'b0;
        winner_c    = PLAYER1;
        run_filled  = 1'b0;
        run_p1      = 1'b0;
        run_p2      = 1'b0;
        rr          = 0;
        cc          = 0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                for (int unsigned dir = 0; dir < 2; dir++) begin
                    run_filled = 1'b1;
                    run_p1     = 1'b1;
                    run_p2     = 1'b1;
                    for (int unsigned k = 0; k < WIN_LEN; k++) begin
                        rr = (dir == 1) ? r + k : r;
                        cc = (dir == 0) ? c + k : c;
                        if (rr < ROWS && cc < COLS) begin
                            run_filled = run_filled & gameboard_i[IW'(cell_idx(rr, cc, COLS))];
                            run_p1     = run_p1 & (players_i[IW'(cell_idx(rr, cc, COLS))] == PLAYER1);
                            run_p2     = run_p2 & (players_i[IW'(cell_idx(rr, cc, COLS))] == PLAYER2);
                        end else begin
                            run_filled = 1'b0;
                        end
                    end
                    if (run_filled && (run_p1 || run_p2) && !win_valid_c) begin
                        win_valid_c = 1'b1;
                        winner_c    = run_p2 ? PLAYER2 : PLAYER1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/board_drop_engine.sv
// Board drop engine: accepts column drops, stacks pieces per column, alternates
// players and reports board-full / win status.
// Optional feature: define WIN_DETECT_EN to build the win detector.
module board_drop_engine
    import board_drop_engine_pkg::*;
#(
    parameter int unsigned ROWS    = 4,
    parameter int unsigned COLS    = 4,
    parameter int unsigned WIN_LEN = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 new_game,
    board_drop_engine_if.slave   drop_if,
    output logic [ROWS*COLS-1:0] out_gameboard,
    output logic [ROWS*COLS-1:0] out_players_cells,
    output logic                 next_player,
    output logic                 board_full,
    output logic                 win_valid,
    output logic                 winner
);
    localparam int unsigned CELLS = ROWS * COLS;
    localparam int unsigned HW    = $clog2(ROWS + 1);
    localparam int unsigned CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned IW    = (CELLS > 1) ? $clog2(CELLS) : 1;

    state_e           state_q;
    logic [HW-1:0]    height_q [COLS];
    logic [CW-1:0]    col_q;
    logic [IW-1:0]    cell_q;
    logic             legal_q;
    logic [CELLS-1:0] board_q;
    logic [CELLS-1:0] owner_q;
    logic             next_player_q;
    logic             board_full_q;
    logic             win_valid_q;
    logic             winner_q;
    logic             drop_ready_q;
    logic             drop_accept_q;
    logic             drop_reject_q;

    logic [HW-1:0]    req_height_c;
    logic             req_hit_c;
    logic             req_legal_c;
    logic             full_c;
    logic             win_c;
    logic             win_owner_c;

    // Height of the requested column; an index at or beyond COLS matches nothing.
    always_comb begin
        req_height_c = '0;
        req_hit_c    = 1'b0;
        for (int unsigned c = 0; c < COLS; c++) begin
            if (drop_if.drop_column == CW'(c)) begin
                req_height_c = height_q[c];
                req_hit_c    = 1'b1;
            end
        end
    end

    assign req_legal_c = req_hit_c && (req_height_c < HW'(ROWS));
    assign full_c      = &board_q;

`ifdef WIN_DETECT_EN
    board_win_detect #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .WIN_LEN (WIN_LEN)
    ) u_win_detect (
        .gameboard_i (board_q),
        .players_i   (owner_q),
        .win_valid_c (win_c),
        .winner_c    (win_owner_c)
    );
`else
    logic unused_win_len;
    assign win_c          = 1'b0;
    assign win_owner_c    = 1'b0;
    assign unused_win_len = ^32'(WIN_LEN);
`endif

    // Move sequencer: legality is decided at the handshake so accept/reject can
    // be a registered pulse during the commit cycle.
    always_ff @(posedge clk) begin
        if (reset || new_game) begin
            state_q       <= S_READY;
            col_q         <= '0;
            cell_q        <= '0;
            legal_q       <= 1'b0;
            board_q       <= '0;
            owner_q       <= '0;
            next_player_q <= PLAYER1;
            board_full_q  <= 1'b0;
            win_valid_q   <= 1'b0;
            winner_q      <= 1'b0;
            drop_ready_q  <= 1'b1;
            drop_accept_q <= 1'b0;
            drop_reject_q <= 1'b0;
            for (int unsigned c = 0; c < COLS; c++) begin
                height_q[c] <= '0;
            end
        end else begin
            drop_accept_q <= 1'b0;
            drop_reject_q <= 1'b0;
            case (state_q)
                S_READY: begin
                    if (drop_if.drop_valid && drop_ready_q) begin
                        col_q         <= drop_if.drop_column;
                        cell_q        <= IW'(cell_idx(32'(req_height_c), 32'(drop_if.drop_column), COLS));
                        legal_q       <= req_legal_c;
                        drop_accept_q <= req_legal_c;
                        drop_reject_q <= !req_legal_c;
                        drop_ready_q  <= 1'b0;
                        state_q       <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    if (legal_q) begin
                        board_q[cell_q] <= 1'b1;
                        owner_q[cell_q] <= next_player_q;
                        next_player_q   <= ~next_player_q;
                        for (int unsigned c = 0; c < COLS; c++) begin
                            if (col_q == CW'(c) && height_q[c] < HW'(ROWS)) begin
                                height_q[c] <= height_q[c] + 1'b1;
                            end
                        end
                        state_q <= S_CHECK;
                    end else begin
                        drop_ready_q <= 1'b1;
                        state_q      <= S_READY;
                    end
                end
                S_CHECK: begin
                    board_full_q <= full_c;
                    win_valid_q  <= win_c;
                    winner_q     <= win_c & win_owner_c;
                    if (full_c || win_c) begin
                        state_q <= S_END;
                    end else begin
                        drop_ready_q <= 1'b1;
                        state_q      <= S_READY;
                    end
                end
                default: begin
                    // S_END holds everything until a clear.
                end
            endcase
        end
    end

    assign drop_if.drop_ready  = drop_ready_q;
    assign drop_if.drop_accept = drop_accept_q;
    assign drop_if.drop_reject = drop_reject_q;
    assign out_gameboard       = board_q;
    assign out_players_cells   = owner_q;
    assign next_player         = next_player_q;
    assign board_full          = board_full_q;
    assign win_valid           = win_valid_q;
    assign winner              = winner_q;

endmodule

// File: tb/tb_board_drop_engine.sv
// Self-checking bench for board_drop_engine (4x4 main instance, 4x3 side
// instance for out-of-range columns). Works with or without WIN_DETECT_EN.
module tb_board_drop_engine;
    localparam int ROWS    = 4;
    localparam int COLS    = 4;
    localparam int WIN_LEN = 4;
    localparam int N       = ROWS * COLS;
    localparam int N3      = ROWS * 3;
`ifdef WIN_DETECT_EN
    localparam bit WIN_EN = 1'b1;
`else
    localparam bit WIN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic new_game;

    board_drop_engine_if #(.COLS(COLS)) m_if ();
    board_drop_engine_if #(.COLS(3))    m3_if ();

    logic [N-1:0]  gb, pl;
    logic          np, bf, wv, wn;
    logic [N3-1:0] gb3, pl3;
    logic          np3, bf3, wv3, wn3;

    board_drop_engine #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN)) u_dut (
        .clk               (clk),
        .reset             (reset),
        .new_game          (new_game),
        .drop_if           (m_if),
        .out_gameboard     (gb),
        .out_players_cells (pl),
        .next_player       (np),
        .board_full        (bf),
        .win_valid         (wv),
        .winner            (wn)
    );

    board_drop_engine #(.ROWS(ROWS), .COLS(3), .WIN_LEN(WIN_LEN)) u_dut3 (
        .clk               (clk),
        .reset             (reset),
        .new_game          (new_game),
        .drop_if           (m3_if),
        .out_gameboard     (gb3),
        .out_players_cells (pl3),
        .next_player       (np3),
        .board_full        (bf3),
        .win_valid         (wv3),
        .winner            (wn3)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: board as an owner grid ----------------
    int m_h[COLS];
    int m_own[ROWS][COLS];
    bit m_np, m_full, m_win, m_wnr, m_end;

    function automatic void model_clear();
        for (int c = 0; c < COLS; c++) m_h[c] = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) m_own[r][c] = -1;
        m_np = 0; m_full = 0; m_win = 0; m_wnr = 0; m_end = 0;
    endfunction

    function automatic void model_score();
`ifdef WIN_DETECT_EN
        int run, prev, o;
`endif
        m_full = 1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (m_own[r][c] < 0) m_full = 0;
        m_win = 0;
        m_wnr = 0;
`ifdef WIN_DETECT_EN
        for (int r = 0; r < ROWS; r++) begin
            run = 0; prev = -1;
            for (int c = 0; c < COLS; c++) begin
                o = m_own[r][c];
                if (o >= 0 && o == prev) run++; else run = (o >= 0) ? 1 : 0;
                prev = o;
                if (run >= WIN_LEN && !m_win) begin m_win = 1; m_wnr = o[0]; end
            end
        end
        for (int c = 0; c < COLS; c++) begin
            run = 0; prev = -1;
            for (int r = 0; r < ROWS; r++) begin
                o = m_own[r][c];
                if (o >= 0 && o == prev) run++; else run = (o >= 0) ? 1 : 0;
                prev = o;
                if (run >= WIN_LEN && !m_win) begin m_win = 1; m_wnr = o[0]; end
            end
        end
`endif
        m_end = m_full || m_win;
    endfunction

    function automatic bit model_drop(input int col);
        if (col >= COLS || m_h[col] >= ROWS) return 1'b0;
        m_own[m_h[col]][col] = int'(m_np);
        m_h[col]++;
        m_np = ~m_np;
        model_score();
        return 1'b1;
    endfunction

    function automatic logic [N-1:0] model_gb();
        logic [N-1:0] v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) v[r*COLS+c] = (m_own[r][c] >= 0);
        return v;
    endfunction

    function automatic logic [N-1:0] model_pl();
        logic [N-1:0] v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) v[r*COLS+c] = (m_own[r][c] == 1);
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        @(posedge clk);
        #1 new_game = 1'b0;
    endtask

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_if.drop_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL ready_timeout: drop_ready got 0 expected 1 within 20 cycles");
        end
    endtask

    // One handshake; samples pulses in the commit cycle, drop_ready one cycle
    // before the expected return, and the board once the move has settled.
    task automatic drop_obs(input int col, output bit acc, output bit rej,
                            output logic [N-1:0] g, output logic [N-1:0] p,
                            output bit np_o, output bit rdy_pre, output bit rdy);
        wait_ready();
        m_if.drop_valid  = 1'b1;
        m_if.drop_column = 2'(col);
        @(posedge clk); #1;
        m_if.drop_valid = 1'b0;
        acc     = m_if.drop_accept;
        rej     = m_if.drop_reject;
        rdy_pre = m_if.drop_ready;
        @(posedge clk); #1;
        if (acc) begin
            rdy_pre = m_if.drop_ready;
            @(posedge clk); #1;
        end
        g = gb; p = pl; np_o = np; rdy = m_if.drop_ready;
    endtask

    task automatic drop_check(input int col, input string tag);
        bit acc, rej, np_o, rdy_pre, rdy, legal;
        logic [N-1:0] g, p;
        legal = model_drop(col);
        drop_obs(col, acc, rej, g, p, np_o, rdy_pre, rdy);
        check({tag, " accept"}, 64'(acc), 64'(legal));
        check({tag, " reject"}, 64'(rej), 64'(!legal));
        check({tag, " board"}, 64'(g), 64'(model_gb()));
        check({tag, " owners"}, 64'(p), 64'(model_pl()));
        check({tag, " next_player"}, 64'(np_o), 64'(m_np));
        check({tag, " ready_early"}, 64'(rdy_pre), 64'(0));
        check({tag, " ready"}, 64'(rdy), 64'(legal ? !m_end : 1'b1));
        check({tag, " board_full"}, 64'(bf), 64'(m_full));
        check({tag, " win_valid"}, 64'(wv), 64'(m_win));
        check({tag, " winner"}, 64'(wn), 64'(m_wnr));
    endtask

    // Drop requests while the game is over must be ignored.
    task automatic check_ignored(input string tag);
        logic [N-1:0] exp_g = model_gb();
        m_if.drop_valid  = 1'b1;
        m_if.drop_column = 2'($urandom_range(0, COLS - 1));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check({tag, " no_pulse"}, 64'(m_if.drop_accept | m_if.drop_reject), 64'(0));
            check({tag, " ready_low"}, 64'(m_if.drop_ready), 64'(0));
            check({tag, " board_held"}, 64'(gb), 64'(exp_g));
        end
        m_if.drop_valid = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " board"}, 64'(gb), 64'(0));
        check({tag, " owners"}, 64'(pl), 64'(0));
        check({tag, " flags"}, 64'({np, bf, wv, wn, m_if.drop_accept, m_if.drop_reject}), 64'(0));
        check({tag, " ready"}, 64'(m_if.drop_ready), 64'(1));
    endtask

    // Handshake and new_game together: the clear wins, nothing is placed.
    task automatic collision(input string tag);
        wait_ready();
        m_if.drop_valid  = 1'b1;
        m_if.drop_column = 2'($urandom_range(0, COLS - 1));
        new_game         = 1'b1;
        @(posedge clk); #1;
        m_if.drop_valid = 1'b0;
        new_game        = 1'b0;
        check({tag, " pulse0"}, 64'(m_if.drop_accept | m_if.drop_reject), 64'(0));
        @(posedge clk); #1;
        check({tag, " pulse1"}, 64'(m_if.drop_accept | m_if.drop_reject), 64'(0));
        check_cleared(tag);
        model_clear();
    endtask

    typedef struct {
        int           col;
        bit           acc;
        logic [N-1:0] g;
        logic [N-1:0] p;
        bit           np;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int   order[16];
        bit   acc, rej, np_o, rdy_pre, rdy;
        logic [N-1:0] g, p;

        tbl[0] = '{1, 1'b1, 16'h0002, 16'h0000, 1'b1};
        tbl[1] = '{1, 1'b1, 16'h0022, 16'h0020, 1'b0};
        tbl[2] = '{1, 1'b1, 16'h0222, 16'h0020, 1'b1};
        tbl[3] = '{1, 1'b1, 16'h2222, 16'h2020, 1'b0};
        tbl[4] = '{1, 1'b0, 16'h2222, 16'h2020, 1'b0};
        tbl[5] = '{2, 1'b1, 16'h2226, 16'h2020, 1'b1};
        order  = '{0, 1, 2, 3, 1, 0, 3, 2, 0, 1, 2, 3, 1, 0, 3, 2};

        reset = 1'b1; new_game = 1'b0;
        m_if.drop_valid = 1'b0;  m_if.drop_column = '0;
        m3_if.drop_valid = 1'b0; m3_if.drop_column = '0;

        // Reset state
        do_reset();
        check_cleared("reset");
        check("reset dut3", 64'({gb3, pl3, np3, bf3, wv3, wn3, m3_if.drop_ready}), 64'(1));

        // Single drop into column 2 with exact latency
        drop_obs(2, acc, rej, g, p, np_o, rdy_pre, rdy);
        check("first accept", 64'({acc, rej}), 64'(2'b10));
        check("first board", 64'(g), 64'(16'h0004));
        check("first owners", 64'(p), 64'(0));
        check("first next_player", 64'(np_o), 64'(1));
        check("first ready_n2", 64'(rdy_pre), 64'(0));
        check("first ready_n3", 64'(rdy), 64'(1));

        // Column stack up to overflow, then another column
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drop_obs(tbl[i].col, acc, rej, g, p, np_o, rdy_pre, rdy);
            check($sformatf("tbl%0d accept", i), 64'(acc), 64'(tbl[i].acc));
            check($sformatf("tbl%0d reject", i), 64'(rej), 64'(!tbl[i].acc));
            check($sformatf("tbl%0d board", i), 64'(g), 64'(tbl[i].g));
            check($sformatf("tbl%0d owners", i), 64'(p), 64'(tbl[i].p));
            check($sformatf("tbl%0d next_player", i), 64'(np_o), 64'(tbl[i].np));
            check($sformatf("tbl%0d ready", i), 64'({rdy_pre, rdy}), 64'(2'b01));
        end

        // Out-of-range column on the 3-column instance
        do_reset();
        m3_if.drop_valid = 1'b1; m3_if.drop_column = 2'd3;
        @(posedge clk); #1;
        m3_if.drop_valid = 1'b0;
        check("col3 pulses", 64'({m3_if.drop_accept, m3_if.drop_reject}), 64'(2'b01));
        @(posedge clk); #1;
        check("col3 board", 64'({gb3, pl3, np3}), 64'(0));
        check("col3 ready", 64'(m3_if.drop_ready), 64'(1));
        m3_if.drop_valid = 1'b1; m3_if.drop_column = 2'd2;
        @(posedge clk); #1;
        m3_if.drop_valid = 1'b0;
        check("col2 dut3 pulses", 64'({m3_if.drop_accept, m3_if.drop_reject}), 64'(2'b10));
        repeat (2) @(posedge clk); #1;
        check("col2 dut3 board", 64'({gb3, pl3, np3, bf3, wv3, wn3}), 64'({12'h004, 12'h000, 4'b1000}));
        check("col2 dut3 ready", 64'(m3_if.drop_ready), 64'(1));

        // Reset during the commit cycle aborts the move
        do_reset();
        m_if.drop_valid = 1'b1; m_if.drop_column = 2'd0;
        @(posedge clk); #1;
        m_if.drop_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_cleared("abort");

        // new_game together with a handshake
        do_reset();
        collision("collide");

        // Bottom-row run for player 1
        do_reset();
        model_clear();
        drop_check(0, "win m1"); drop_check(0, "win m2");
        drop_check(1, "win m3"); drop_check(1, "win m4");
        drop_check(2, "win m5"); drop_check(2, "win m6");
        drop_check(3, "win m7");
        check("win flag", 64'({wv, wn}), 64'({WIN_EN, 1'b0}));
        check("win ready", 64'(m_if.drop_ready), 64'(!WIN_EN));
`ifdef WIN_DETECT_EN
        check_ignored("win end");
`endif

        // Full board without a run, then clear
        do_reset();
        model_clear();
        for (int i = 0; i < 16; i++) drop_check(order[i], $sformatf("fill%0d", i));
        check("fill board", 64'({gb, pl}), 64'({16'hFFFF, 16'h5A5A}));
        check("fill full", 64'({bf, wv}), 64'(2'b10));
        check_ignored("fill end");
        pulse_new_game();
        check_cleared("fill clear");
        model_clear();

        // Randomized play against the model
        for (int it = 0; it < 300; it++) begin
            if (m_end) begin
                check_ignored("rnd end");
                pulse_new_game();
                check_cleared("rnd clear");
                model_clear();
            end else if ($urandom_range(0, 15) == 0) begin
                collision("rnd collide");
            end else begin
                drop_check(int'($urandom_range(0, COLS - 1)), "rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/board_drop_engine.md
BOARD_DROP_ENGINE -- requirements
Module: board_drop_engine

Interface
REQ-001 SHALL expose parameter ROWS, default 4, board rows; row 0 is the bottom row.
REQ-002 SHALL expose parameter COLS, default 4, board columns.
REQ-003 SHALL expose parameter WIN_LEN, default 4, run length that wins.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port new_game  input  1  synchronous board clear, same effect as reset.
REQ-007 SHALL have port drop_valid  input  1  drop request present.
REQ-008 SHALL have port drop_column  input  $clog2(COLS)  requested column; sampled only when drop_valid and drop_ready are both high.
REQ-009 SHALL have port drop_ready  output  1  engine can take a request.
REQ-010 SHALL have port drop_accept  output  1  one-cycle pulse: piece placed.
REQ-011 SHALL have port drop_reject  output  1  one-cycle pulse: request refused.
REQ-012 SHALL have port out_gameboard  output  ROWS*COLS  occupancy bitmap, 1 = filled; bit index = row*COLS+col.
REQ-013 SHALL have port out_players_cells  output  ROWS*COLS  owner bitmap, 0 = player1, 1 = player2; bits are 0 where the cell is empty.
REQ-014 SHALL have port next_player  output  1  0 = player1 to move, 1 = player2 to move.
REQ-015 SHALL have port board_full  output  1  all cells filled.
REQ-016 SHALL have port win_valid  output  1  a winning run exists.
REQ-017 SHALL have port winner  output  1  owner of the winning run; valid only while win_valid is high.

Function
REQ-018 SHALL implement states S_READY, S_COMMIT, S_CHECK and S_END.
REQ-019 drop_ready SHALL be high only in S_READY.
REQ-020 S_READY: on drop_valid and drop_ready at edge N, SHALL latch drop_column and go to S_COMMIT for cycle N+1.
REQ-021 S_COMMIT, request legal (column < COLS and column height < ROWS): SHALL assert drop_accept for that cycle only.
REQ-022 S_COMMIT, request legal: at the end of the cycle SHALL set the cell (height, column) in out_gameboard, write next_player into out_players_cells at that cell, increment the column height, toggle next_player, and go to S_CHECK.
REQ-023 S_COMMIT, request illegal (column >= COLS or column full): SHALL assert drop_reject for that cycle only, leave the board and next_player unchanged, and return to S_READY.
REQ-024 S_CHECK SHALL evaluate board_full and the win detector on the committed board.
REQ-025 S_CHECK SHALL go to S_END if win_valid or board_full is high, otherwise to S_READY.
REQ-026 Accept-to-ready latency SHALL be exactly 3 cycles after the handshake edge; reject-to-ready latency SHALL be 2 cycles.
REQ-027 S_END SHALL hold the board and all status outputs, keep drop_ready low, and ignore drop_valid; it is left only by new_game or reset.
REQ-028 new_game SHALL be honoured in any state and SHALL take priority over a simultaneous handshake; the pending drop is discarded.
REQ-029 board_full, win_valid and winner SHALL be registered outputs that change only at the end of S_CHECK or on clear.
REQ-030 Per-column height counters SHALL be $clog2(ROWS+1) bits wide and SHALL saturate at ROWS, never wrap.
REQ-031 drop_accept and drop_reject SHALL never be high in the same cycle.

Reset
REQ-032 On reset or new_game the block SHALL clear out_gameboard, out_players_cells and all heights to 0, clear next_player, board_full, win_valid, winner, drop_accept and drop_reject to 0, and enter S_READY; drop_ready SHALL be 1 on the following cycle.
REQ-033 Reset asserted in the middle of a move SHALL abort the move with no partial board write.

Configuration
REQ-034 With WIN_DETECT_EN defined, S_CHECK SHALL flag any horizontal or vertical run of WIN_LEN cells that are all filled and share one owner, and winner SHALL equal that owner.
REQ-035 Without WIN_DETECT_EN, win_valid and winner SHALL be constant 0, no detector logic SHALL be synthesised, and S_END SHALL be reached only through board_full.

Structure
REQ-036 A shared package SHALL hold the state encoding, the player constants (PLAYER1=0, PLAYER2=1) and the cell-index function row*COLS+col.
REQ-037 The win detector SHALL be one sub-module, board_win_detect, taking both bitmaps and returning win_valid and winner; it is instantiated only under WIN_DETECT_EN.

Verification
REQ-038 Reset, then drop column 2 -> drop_accept at N+1; bit 2 of out_gameboard = 1; bit 2 of out_players_cells = 0; next_player = 1; drop_ready = 1 at N+3.
REQ-039 Five drops into column 1 with ROWS=4 -> drops 1-4 fill bits 1, 5, 9, 13 alternating owner 0/1/0/1; drop 5 gives drop_reject, board unchanged, next_player unchanged.
REQ-040 drop_column = 3 with COLS=3 -> drop_reject, no board change.
REQ-041 WIN_DETECT_EN, moves P1:0, P2:0, P1:1, P2:1, P1:2, P2:2, P1:3 -> after the 7th move win_valid = 1, winner = 0, state S_END, further drop_valid ignored.
REQ-042 Fill all 16 cells with no run (WIN_DETECT_EN undefined) -> board_full = 1 after the last S_CHECK, drop_ready stays 0; new_game -> all outputs 0 on the next cycle.
REQ-043 Assert new_game in the same cycle as a handshake -> no drop_accept or drop_reject, board stays empty.
